// File: rtl/mmio_pkg.sv
// Shared definitions for memory-mapped peripherals on the CPU data bus.
//   mem_write_e : store-size encoding carried on mem_write
//   REG_*       : 4-bit register indices (addr[5:2]) of the GPIO block
//   lane_merge  : places store data into its byte/half lane(s) over a base word
package mmio_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_BYTE = 2'b01,
    MW_HALF = 2'b10,
    MW_WORD = 2'b11
  } mem_write_e;

  localparam logic [3:0] REG_IN      = 4'h0;
  localparam logic [3:0] REG_OUT     = 4'h1;
  localparam logic [3:0] REG_OUT_SET = 4'h2;
  localparam logic [3:0] REG_OUT_CLR = 4'h3;
  localparam logic [3:0] REG_OUT_TGL = 4'h4;
  localparam logic [3:0] REG_RISE_EN = 4'h5;
  localparam logic [3:0] REG_FALL_EN = 4'h6;
  localparam logic [3:0] REG_FLAGS   = 4'h7;
  localparam logic [3:0] REG_IRQ_EN  = 4'h8;

  // Bytes not covered by the store keep their value from 'base'. Pass the
  // current register for read-modify-write registers, or zero for
  // set/clear/toggle/W1C style registers so untouched lanes act as 0.
  function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                             input logic [31:0] wdata,
                                             input mem_write_e  mw,
                                             input logic [1:0]  lane);
    logic [31:0] r;
    r = base;
    case (mw)
      MW_WORD: r = wdata;
      MW_HALF: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      MW_BYTE: r[{lane, 3'b000} +: 8] = wdata[7:0];
      default: r = base;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mmio_gpio_if.sv
// CPU data-bus slave port of a memory-mapped peripheral.
//   addr      : byte address
//   wdata     : store data, LSB-aligned
//   mem_write : store size (see mmio_pkg::mem_write_e), 00 = no store
//   rdata     : combinational read data, 0 when the block is not addressed
//   hit       : address lies inside the peripheral's window
// Handshake: there is no valid/ready pair. A store is accepted on the rising
// clk edge where hit && mem_write != 00; reads are pure combinational lookups
// with no side effects, so the master may sample rdata at any time.
interface mmio_gpio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  mem_write;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, output wdata, output mem_write,
                  input  rdata, input  hit);
  modport slave  (input  addr, input  wdata, input  mem_write,
                  output rdata, output hit);
endinterface

// File: rtl/mmio_gpio_in_filter.sv
// One GPIO input channel: multi-flop synchroniser followed by a debouncer.
//   clk, reset : system clock, asynchronous active-low reset
//   pin        : raw asynchronous pin
//   stable     : debounced value
//   update     : high in the cycle whose clock edge will change 'stable'
//   sample     : synchronised pin value ('stable' takes it when update is high)
module gpio_in_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic update,
  output logic sample
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   stable_q;
  logic                   s;

  assign s      = sync_q[SYNC_STAGES-1];
  // The stable value flips only after DEBOUNCE_CYCLES consecutive cycles of
  // disagreement; any agreeing cycle in between restarts the count.
  assign update = (s != stable_q) && (cnt_q == CNT_LAST);
  assign stable = stable_q;
  assign sample = s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      if (s == stable_q) begin
        cnt_q <= '0;
      end else if (update) begin
        stable_q <= s;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO peripheral with debounced inputs, set/clear/toggle
// output aliases, rise/fall edge flags and a registered level interrupt.
//   clk, reset : system clock, asynchronous active-low reset
//   bus        : CPU data-bus slave port (addr, wdata, mem_write, rdata, hit)
//   gpio_in    : asynchronous input pins
//   gpio_out   : output pins, driven straight from the OUT register
//   irq        : level interrupt, |(FLAGS & IRQ_EN) registered
module mmio_gpio
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
  parameter int          N_IN            = 16,
  parameter int          N_OUT           = 16,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] OUT_RESET       = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  mmio_gpio_if.slave       bus,
  input  logic [N_IN-1:0]  gpio_in,
  output logic [N_OUT-1:0] gpio_out,
  output logic             irq
);

  logic [3:0]       idx;
  logic [1:0]       lane;
  mem_write_e       mw;
  logic             hit_c;
  logic             we;

  logic [N_OUT-1:0] out_q, out_n;
  logic [N_IN-1:0]  rise_en_q, rise_en_n;
  logic [N_IN-1:0]  fall_en_q, fall_en_n;
  logic [N_IN-1:0]  irq_en_q, irq_en_n;
  logic [N_IN-1:0]  flags_q, flags_n;
  logic [N_IN-1:0]  w1c;
  logic [N_IN-1:0]  rise, fall;
  logic             irq_q;

  logic [N_IN-1:0]  in_stable, in_update, in_sample;

  logic [31:0]      v_alias, v_out, v_rise, v_fall, v_irq_en;
  logic [31:0]      rdata_c;

  assign idx   = bus.addr[5:2];
  assign lane  = bus.addr[1:0];
  assign mw    = mem_write_e'(bus.mem_write);
  assign hit_c = (bus.addr[31:6] == BASE_ADDR[31:6]);
  assign we    = hit_c && (mw != MW_NONE);

  // ---------------------------------------------------------------- inputs
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    gpio_in_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk    (clk),
      .reset  (reset),
      .pin    (gpio_in[i]),
      .stable (in_stable[i]),
      .update (in_update[i]),
      .sample (in_sample[i])
    );
  end

  // ---------------------------------------------------------- store values
  assign v_alias  = lane_merge(32'h0,           bus.wdata, mw, lane);
  assign v_out    = lane_merge(32'(out_q),      bus.wdata, mw, lane);
  assign v_rise   = lane_merge(32'(rise_en_q),  bus.wdata, mw, lane);
  assign v_fall   = lane_merge(32'(fall_en_q),  bus.wdata, mw, lane);
  assign v_irq_en = lane_merge(32'(irq_en_q),   bus.wdata, mw, lane);

  // Bits above the channel counts are dropped on purpose.
  logic unused_hi;
  assign unused_hi = ^{v_alias, v_out, v_rise, v_fall, v_irq_en};

  always_comb begin
    out_n     = out_q;
    rise_en_n = rise_en_q;
    fall_en_n = fall_en_q;
    irq_en_n  = irq_en_q;
    w1c       = '0;
    if (we) begin
      case (idx)
        REG_OUT:     out_n     = v_out[N_OUT-1:0];
        REG_OUT_SET: out_n     = out_q |  v_alias[N_OUT-1:0];
        REG_OUT_CLR: out_n     = out_q & ~v_alias[N_OUT-1:0];
        REG_OUT_TGL: out_n     = out_q ^  v_alias[N_OUT-1:0];
        REG_RISE_EN: rise_en_n = v_rise[N_IN-1:0];
        REG_FALL_EN: fall_en_n = v_fall[N_IN-1:0];
        REG_FLAGS:   w1c       = v_alias[N_IN-1:0];
        REG_IRQ_EN:  irq_en_n  = v_irq_en[N_IN-1:0];
        default:     ;
      endcase
    end
    // Edges are taken from the debouncer's update strobe so a flag lands on
    // the same edge as the IN change. New edges are OR-ed in after the W1C
    // mask, so a set beats a simultaneous clear.
    rise    = in_update &  in_sample & rise_en_q;
    fall    = in_update & ~in_sample & fall_en_q;
    flags_n = (flags_q & ~w1c) | rise | fall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q     <= OUT_RESET[N_OUT-1:0];
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_en_q  <= '0;
      flags_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_n;
      rise_en_q <= rise_en_n;
      fall_en_q <= fall_en_n;
      irq_en_q  <= irq_en_n;
      flags_q   <= flags_n;
      irq_q     <= |(flags_q & irq_en_q);
    end
  end

  // ----------------------------------------------------------------- reads
  always_comb begin
    rdata_c = '0;
    if (hit_c) begin
      case (idx)
        REG_IN:      rdata_c = 32'(in_stable);
        REG_OUT:     rdata_c = 32'(out_q);
        REG_RISE_EN: rdata_c = 32'(rise_en_q);
        REG_FALL_EN: rdata_c = 32'(fall_en_q);
        REG_FLAGS:   rdata_c = 32'(flags_q);
        REG_IRQ_EN:  rdata_c = 32'(irq_en_q);
        default:     rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.hit   = hit_c;
  assign gpio_out  = out_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_mmio_gpio.sv
module tb_mmio_gpio;

  // ------------------------------------------------------ clock and reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;

  mmio_gpio_if bus();

  mmio_gpio #(
    .BASE_ADDR      (32'h0000_1000),
    .N_IN           (16),
    .N_OUT          (16),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .OUT_RESET      (32'h0000_00A5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------- driver tasks
  // Called right after a falling edge; the store lands on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
    bus.addr      = a;
    bus.wdata     = d;
    bus.mem_write = mw;
    @(negedge clk);
    bus.mem_write = 2'b00;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] want;
    bus.addr      = a;
    bus.mem_write = 2'b00;
    exp_q.push_back(e);
    #1;
    want = exp_q.pop_front();
    check(name, bus.rdata, want);
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [1:0]  mw;
    logic [31:0] ra;
    logic [31:0] exp;
    logic        exp_hit;
    string       name;
  } vec_t;

  vec_t        vecs[23];
  logic [31:0] m;

  initial begin
    vecs[0]  = '{32'h1004, 32'h0000_F00F, 2'b11, 32'h1004, 32'h0000_F00F, 1'b1, "out_word"};
    vecs[1]  = '{32'h1008, 32'h0000_00F0, 2'b11, 32'h1004, 32'h0000_F0FF, 1'b1, "out_set"};
    vecs[2]  = '{32'h100C, 32'h0000_000F, 2'b11, 32'h1004, 32'h0000_F0F0, 1'b1, "out_clr"};
    vecs[3]  = '{32'h1010, 32'h0000_0001, 2'b11, 32'h1004, 32'h0000_F0F1, 1'b1, "out_tgl"};
    vecs[4]  = '{32'h1004, 32'h0000_FFFF, 2'b11, 32'h1004, 32'h0000_FFFF, 1'b1, "out_ffff"};
    vecs[5]  = '{32'h1005, 32'h0000_003C, 2'b01, 32'h1004, 32'h0000_3CFF, 1'b1, "out_byte1"};
    vecs[6]  = '{32'h2004, 32'h0000_0000, 2'b11, 32'h2004, 32'h0000_0000, 1'b0, "miss_rd"};
    vecs[7]  = '{32'h0000, 32'h0000_0000, 2'b00, 32'h1004, 32'h0000_3CFF, 1'b1, "miss_no_write"};
    vecs[8]  = '{32'h1006, 32'h0000_1234, 2'b10, 32'h1004, 32'h0000_3CFF, 1'b1, "half_hi_masked"};
    vecs[9]  = '{32'h1004, 32'h0000_ABCD, 2'b10, 32'h1004, 32'h0000_ABCD, 1'b1, "half_lo"};
    vecs[10] = '{32'h100B, 32'h0000_00FF, 2'b01, 32'h1004, 32'h0000_ABCD, 1'b1, "set_byte3"};
    vecs[11] = '{32'h1010, 32'h0000_000F, 2'b01, 32'h1004, 32'h0000_ABC2, 1'b1, "tgl_byte0"};
    vecs[12] = '{32'h100D, 32'h0000_0001, 2'b01, 32'h1004, 32'h0000_AAC2, 1'b1, "clr_byte1"};
    vecs[13] = '{32'h1014, 32'hFFFF_FFFF, 2'b11, 32'h1014, 32'h0000_FFFF, 1'b1, "rise_en_word"};
    vecs[14] = '{32'h1015, 32'h0000_0000, 2'b01, 32'h1014, 32'h0000_00FF, 1'b1, "rise_en_byte"};
    vecs[15] = '{32'h1014, 32'h0000_0008, 2'b11, 32'h1014, 32'h0000_0008, 1'b1, "rise_en_8"};
    vecs[16] = '{32'h0000, 32'h0000_0000, 2'b00, 32'h1018, 32'h0000_0000, 1'b1, "fall_en_rst"};
    vecs[17] = '{32'h1020, 32'h0000_0008, 2'b11, 32'h1020, 32'h0000_0008, 1'b1, "irq_en_8"};
    vecs[18] = '{32'h1030, 32'hFFFF_FFFF, 2'b11, 32'h1030, 32'h0000_0000, 1'b1, "unmapped"};
    vecs[19] = '{32'h1008, 32'h0000_0000, 2'b11, 32'h1008, 32'h0000_0000, 1'b1, "alias_rd"};
    vecs[20] = '{32'h0000, 32'h0000_0000, 2'b00, 32'h103C, 32'h0000_0000, 1'b1, "last_idx"};
    vecs[21] = '{32'h0000, 32'h0000_0000, 2'b00, 32'h0FFC, 32'h0000_0000, 1'b0, "below_base"};
    vecs[22] = '{32'h1000, 32'h0000_FFFF, 2'b11, 32'h1000, 32'h0000_0000, 1'b1, "in_ro"};

    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.mem_write = 2'b00;
    gpio_in       = 16'h0;
    reset         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gpio_out_held", {16'h0, gpio_out}, 32'h0000_00A5);
    reset = 1'b1;

    // ---- reset state
    @(negedge clk);
    check("rst_gpio_out", {16'h0, gpio_out}, 32'h0000_00A5);
    check("rst_irq", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd($sformatf("rst_reg%0d", i), 32'h1000 + 32'(i * 4), (i == 1) ? 32'h0000_00A5 : 32'h0);
    end

    // ---- table: store then read back
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (vecs[i].mw != 2'b00) wr(vecs[i].wa, vecs[i].wd, vecs[i].mw);
      rd(vecs[i].name, vecs[i].ra, vecs[i].exp);
      check({vecs[i].name, "_hit"}, {31'h0, bus.hit}, {31'h0, vecs[i].exp_hit});
    end
    check("tbl_gpio_out", {16'h0, gpio_out}, 32'h0000_AAC2);

    // ---- random OUT/SET/CLR/TGL stores against a byte-enable model
    m = 32'h0000_AAC2;
    for (int k = 0; k < 24; k++) begin
      int          op;
      int          sz;
      logic [1:0]  ln;
      logic [31:0] d, be, dp, v;
      op = $urandom_range(1, 4);
      sz = $urandom_range(1, 3);
      ln = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (sz == 1) begin
        be = 32'h0000_00FF << (8 * ln);
        dp = {4{d[7:0]}};
      end else if (sz == 2) begin
        be = ln[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        dp = {2{d[15:0]}};
      end else begin
        be = 32'hFFFF_FFFF;
        dp = d;
      end
      v = dp & be;
      case (op)
        1:       m = (m & ~be) | v;
        2:       m = m | v;
        3:       m = m & ~v;
        default: m = m ^ v;
      endcase
      m = m & 32'h0000_FFFF;
      @(negedge clk);
      wr(32'h1000 + 32'(op * 4) + {30'h0, ln}, d, 2'(sz));
      rd("rand_out", 32'h1004, m);
      check("rand_gpio_out", {16'h0, gpio_out}, m);
    end

    // ---- glitch of 3 cycles on pin 3 is rejected
    @(negedge clk);
    gpio_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (10) @(negedge clk);
    rd("glitch_in", 32'h1000, 32'h0);
    rd("glitch_flags", 32'h101C, 32'h0);

    // ---- held high: IN[3] after exactly 6 edges, flag same edge, irq one later
    @(negedge clk);
    gpio_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    rd("lat5_in", 32'h1000, 32'h0);
    @(negedge clk);
    rd("lat6_in", 32'h1000, 32'h8);
    rd("lat6_flags", 32'h101C, 32'h8);
    check("lat6_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(32'h101C, 32'h8, 2'b11);
    rd("w1c_flags", 32'h101C, 32'h0);
    check("irq_w1c_lag", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // ---- fall flag, then a rise landing on the same edge as a W1C
    wr(32'h1018, 32'h8, 2'b11);
    @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (8) @(negedge clk);
    rd("fall_flags", 32'h101C, 32'h8);
    check("fall_irq", {31'h0, irq}, 32'h1);
    @(negedge clk);
    gpio_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    wr(32'h101C, 32'h8, 2'b11);
    rd("set_wins_flags", 32'h101C, 32'h8);
    rd("set_wins_in", 32'h1000, 32'h8);
    @(negedge clk);
    wr(32'h101C, 32'h8, 2'b11);
    rd("w1c_again", 32'h101C, 32'h0);

    // ---- reset pulse mid-debounce of pin 0
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_gpio_out", {16'h0, gpio_out}, 32'h0000_00A5);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    rd("midrst_in", 32'h1000, 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    rd("post_rst_lat5", 32'h1000, 32'h0);
    @(negedge clk);
    rd("post_rst_lat6", 32'h1000, 32'h9);
    rd("post_rst_flags", 32'h101C, 32'h0);
    rd("post_rst_rise_en", 32'h1014, 32'h0);
    rd("post_rst_out", 32'h1004, 32'h0000_00A5);
    repeat (3) @(negedge clk);
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
